// File: rtl/branch_unit_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit_bht
// Purpose  : Branch resolve unit with a 2-bit saturating branch history table
//            and saturating branch/mispredict performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [2:0]       funct3,
    input  logic             cond_jump,
    input  logic             uncond_jump,
    input  logic             base_addr_sel,
    input  logic             res_pred_taken,
    output logic             out_valid,
    output logic             branch_taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             misaligned,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int              IDX       = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic             r_out_valid;
    logic             r_branch_taken;
    logic             r_mispredict;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [IDX-1:0]   w_pred_idx;
    logic [IDX-1:0]   w_res_idx;
    logic             w_equal;
    logic             w_less_s;
    logic             w_less_u;
    logic [XLEN-1:0]  w_sum;
    logic [XLEN-1:0]  w_target;
    logic             w_cond_taken;
    logic             w_f3_valid;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_update;
    logic [1:0]       w_bht_cur;
    logic [1:0]       w_bht_next;
    logic             w_unused_pred_bits;

    assign w_pred_idx = pred_pc[IDX+1:2];
    assign w_res_idx  = pc[IDX+1:2];
    assign pred_taken = r_bht[w_pred_idx][1];
    assign w_unused_pred_bits = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};

    assign w_equal  = (rs1 == rs2);
    assign w_less_s = ($signed(rs1) < $signed(rs2));
    assign w_less_u = (rs1 < rs2);

    // JALR targets drop bit 0 of the sum; PC-relative targets keep it.
    assign w_sum    = (base_addr_sel ? rs1 : pc) + imm;
    assign w_target = base_addr_sel ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

    always_comb begin
        w_cond_taken = 1'b0;
        case (funct3)
            3'b000:  w_cond_taken = w_equal;
            3'b001:  w_cond_taken = !w_equal;
            3'b100:  w_cond_taken = w_less_s;
            3'b101:  w_cond_taken = !w_less_s;
            3'b110:  w_cond_taken = w_less_u;
            3'b111:  w_cond_taken = !w_less_u;
            default: w_cond_taken = 1'b0;
        endcase
    end

    assign w_f3_valid   = (funct3[2:1] != 2'b01);
    assign w_taken      = cond_jump ? w_cond_taken : uncond_jump;
    assign w_mispredict = cond_jump ? (w_taken != res_pred_taken) : uncond_jump;
    assign w_update     = res_valid && cond_jump && w_f3_valid;

    assign w_bht_cur = r_bht[w_res_idx];

    always_comb begin
        w_bht_next = w_bht_cur;
        if (w_taken && (w_bht_cur != 2'b11)) begin
            w_bht_next = w_bht_cur + 2'd1;
        end else if (!w_taken && (w_bht_cur != 2'b00)) begin
            w_bht_next = w_bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (clk_en && w_update) begin
            r_bht[w_res_idx] <= w_bht_next;
        end
    end

    // Result registers hold their last value when no instruction resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_mispredict   <= 1'b0;
            r_redirect_pc  <= '0;
            r_misaligned   <= 1'b0;
        end else if (clk_en) begin
            r_out_valid <= res_valid;
            if (res_valid) begin
                r_branch_taken <= w_taken;
                r_mispredict   <= w_mispredict;
                r_redirect_pc  <= w_taken ? w_target : (pc + c_pc_step);
                r_misaligned   <= w_taken && w_target[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (clk_en && w_update) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign branch_taken = r_branch_taken;
    assign mispredict   = r_mispredict;
    assign redirect_pc  = r_redirect_pc;
    assign misaligned   = r_misaligned;
    assign branch_cnt   = r_branch_cnt;
    assign mispred_cnt  = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit_bht.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_unit_bht
// Purpose  : Self-checking bench for branch_unit_bht against a behavioural
//            model of the resolve rules and predictor table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_unit_bht;

    localparam int c_xlen    = 32;
    localparam int c_entries = 16;
    localparam int c_cnt_w   = 4;
    localparam int c_cnt_max = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_en = 1'b1;
    logic [31:0]       pred_pc = '0;
    logic              pred_taken;
    logic              res_valid = 1'b0;
    logic [31:0]       rs1 = '0, rs2 = '0, imm = '0, pc = '0;
    logic [2:0]        funct3 = '0;
    logic              cond_jump = 1'b0, uncond_jump = 1'b0;
    logic              base_addr_sel = 1'b0, res_pred_taken = 1'b0;
    logic              out_valid, branch_taken, mispredict, misaligned;
    logic [31:0]       redirect_pc;
    logic [c_cnt_w-1:0] branch_cnt, mispred_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_bht [c_entries];
    logic        m_valid, m_taken, m_misp, m_mis;
    logic [31:0] m_redir;
    int          m_bcnt, m_mcnt;

    branch_unit_bht #(
        .XLEN(c_xlen), .BHT_ENTRIES(c_entries), .CNT_W(c_cnt_w)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .res_valid(res_valid), .rs1(rs1), .rs2(rs2),
        .imm(imm), .pc(pc), .funct3(funct3), .cond_jump(cond_jump),
        .uncond_jump(uncond_jump), .base_addr_sel(base_addr_sel),
        .res_pred_taken(res_pred_taken), .out_valid(out_valid),
        .branch_taken(branch_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .misaligned(misaligned),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < c_entries; i++) m_bht[i] = 1;
        m_valid = 0; m_taken = 0; m_misp = 0; m_mis = 0; m_redir = '0;
        m_bcnt = 0; m_mcnt = 0;
    endtask

    function automatic int model_pred(input logic [31:0] a);
        return (m_bht[int'((a >> 2) % c_entries)] >= 2) ? 1 : 0;
    endfunction

    // Applies the resolve rules to the inputs present just before an edge.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        tk;
        int          idx;
        if (!rst_n || !clk_en) return;
        m_valid = res_valid;
        if (!res_valid) return;
        tgt = (base_addr_sel ? rs1 : pc) + imm;
        if (base_addr_sel) tgt = tgt & ~32'd1;
        tk = 1'b0;
        if (cond_jump) begin
            case (funct3)
                3'd0: tk = (rs1 == rs2);
                3'd1: tk = (rs1 != rs2);
                3'd4: tk = ($signed(rs1) < $signed(rs2));
                3'd5: tk = ($signed(rs1) >= $signed(rs2));
                3'd6: tk = (rs1 < rs2);
                3'd7: tk = (rs1 >= rs2);
                default: tk = 1'b0;
            endcase
        end else begin
            tk = uncond_jump;
        end
        m_taken = tk;
        m_misp  = cond_jump ? (tk != res_pred_taken) : uncond_jump;
        m_redir = tk ? tgt : pc + 32'd4;
        m_mis   = tk && tgt[1];
        if (cond_jump && funct3 != 3'd2 && funct3 != 3'd3) begin
            idx = int'((pc >> 2) % c_entries);
            if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
            else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
            m_bcnt = (m_bcnt < c_cnt_max) ? m_bcnt + 1 : c_cnt_max;
            if (m_misp) m_mcnt = (m_mcnt < c_cnt_max) ? m_mcnt + 1 : c_cnt_max;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cj, input logic uj, input logic bsel,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] p, input logic pt);
        cond_jump = cj; uncond_jump = uj; base_addr_sel = bsel; funct3 = f3;
        rs1 = a; rs2 = b; imm = i; pc = p; res_pred_taken = pt;
        res_valid = 1'b1; clk_en = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res_valid = 1'b0; clk_en = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        pred_pc = 32'h40;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
        res_valid = 1'b1; cond_jump = 1'b1; funct3 = 3'd0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", branch_taken); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_misp: got %b want 0", mispredict); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redir: got %h want 0", redirect_pc); end
        checks++; if (branch_cnt !== '0 || mispred_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
        @(negedge clk);
        res_valid = 1'b0; cond_jump = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_beq();
        do_reset();
        drive(1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 0);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL beq_valid: got %b want 1", out_valid); end
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", branch_taken); end
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_misp: got %b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_redir: got %h want 120", redirect_pc); end
        checks++; if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin errors++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", branch_cnt, mispred_cnt); end
        @(negedge clk);
        res_valid = 1'b0; pred_pc = 32'h100;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_bht_wt: got %b want 1", pred_taken); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", out_valid); end
        checks++; if (redirect_pc !== 32'h120 || branch_taken !== 1'b1) begin errors++; $display("FAIL idle_hold: got %h/%b want 120/1", redirect_pc, branch_taken); end
    endtask

    task automatic test_signed_unsigned();
        do_reset();
        drive(1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 0);
        tick();
        checks++; if (branch_taken !== 1'b1 || redirect_pc !== 32'h50) begin errors++; $display("FAIL blt: got %b/%h want 1/50", branch_taken, redirect_pc); end
        @(negedge clk);
        drive(1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 0);
        tick();
        checks++; if (branch_taken !== 1'b0 || redirect_pc !== 32'h44) begin errors++; $display("FAIL bltu: got %b/%h want 0/44", branch_taken, redirect_pc); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL bltu_misp: got %b want 0", mispredict); end
    endtask

    task automatic test_saturation();
        int exp_pred [7] = '{0, 1, 1, 1, 1, 1, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            // four taken BEQs, then two not-taken BNEs on the same index
            drive(1, 0, 0, (k < 4) ? 3'd0 : 3'd1, 32'd7, 32'd7, 32'h8, 32'h80, 1);
            pred_pc = 32'h80;
            #1;
            checks++; if (pred_taken !== exp_pred[k][0]) begin errors++; $display("FAIL sat_pred[%0d]: got %b want %0d", k, pred_taken, exp_pred[k]); end
            tick();
        end
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        checks++; if (pred_taken !== exp_pred[6][0]) begin errors++; $display("FAIL sat_pred[6]: got %b want %0d", pred_taken, exp_pred[6]); end
        checks++; if (branch_cnt !== 4'd6) begin errors++; $display("FAIL sat_cnt: got %0d want 6", branch_cnt); end
    endtask

    task automatic test_jalr();
        do_reset();
        drive(0, 1, 1, 3'd0, 32'h1001, 32'h0, 32'h2, 32'h300, 0);
        pred_pc = 32'h300;
        tick();
        checks++; if (redirect_pc !== 32'h1002 || branch_taken !== 1'b1) begin errors++; $display("FAIL jalr_target: got %h/%b want 1002/1", redirect_pc, branch_taken); end
        checks++; if (misaligned !== 1'b1 || mispredict !== 1'b1) begin errors++; $display("FAIL jalr_flags: got mis=%b misp=%b want 1/1", misaligned, mispredict); end
        checks++; if (branch_cnt !== 4'd0 || pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_no_update: got cnt=%0d pred=%b want 0/0", branch_cnt, pred_taken); end
    endtask

    task automatic test_clk_en_reset();
        do_reset();
        drive(1, 0, 0, 3'd0, 32'd3, 32'd3, 32'h20, 32'h100, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 0, 0, 3'd1, 32'd1, 32'd2, 32'h40, 32'h100, 0);
            clk_en = 1'b0;
            pred_pc = 32'h100;
            if (k < 2) begin
                tick();
                checks++; if (out_valid !== 1'b1 || redirect_pc !== 32'h120) begin errors++; $display("FAIL gate_out[%0d]: got %b/%h want 1/120", k, out_valid, redirect_pc); end
                checks++; if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1 || pred_taken !== 1'b1) begin errors++; $display("FAIL gate_state[%0d]: got %0d/%0d/%b want 1/1/1", k, branch_cnt, mispred_cnt, pred_taken); end
            end else begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                checks++; if (out_valid !== 1'b0 || branch_taken !== 1'b0 || mispredict !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL async_rst_flags: got %b%b%b%b want 0000", out_valid, branch_taken, mispredict, misaligned); end
                checks++; if (redirect_pc !== 32'h0 || branch_cnt !== '0 || mispred_cnt !== '0 || pred_taken !== 1'b0) begin errors++; $display("FAIL async_rst_state: got %h/%0d/%0d/%b want 0/0/0/0", redirect_pc, branch_cnt, mispred_cnt, pred_taken); end
            end
        end
        clk_en = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || redirect_pc !== 32'h140 || branch_cnt !== 4'd1) begin errors++; $display("FAIL post_rst: got %b/%h/%0d want 1/140/1", out_valid, redirect_pc, branch_cnt); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1, 0, 0, 3'd0, 32'd9, 32'd9, 32'h10, 32'h140, 0);
        pred_pc = 32'h140;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bypass_old: got %b want 0", pred_taken); end
        tick();
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL bypass_new: got %b want 1", pred_taken); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            imm = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) imm = -imm;
            pc = 32'h1000 | (32'($urandom_range(0, 2 * c_entries - 1)) << 2);
            pred_pc = 32'h1000 | (32'($urandom_range(0, c_entries - 1)) << 2);
            funct3 = 3'($urandom_range(0, 7));
            cond_jump = ($urandom_range(0, 2) != 0);
            uncond_jump = ($urandom_range(0, 3) == 0);
            base_addr_sel = 1'($urandom_range(0, 1));
            res_pred_taken = 1'($urandom_range(0, 1));
            res_valid = ($urandom_range(0, 3) != 0);
            clk_en = ($urandom_range(0, 9) != 0);
            #1;
            checks++; if (pred_taken !== 1'(model_pred(pred_pc))) begin errors++; $display("FAIL rnd_pred[%0d]: got %b want %0d", n, pred_taken, model_pred(pred_pc)); end
            tick();
            checks++; if (out_valid !== m_valid || branch_taken !== m_taken || mispredict !== m_misp || misaligned !== m_mis) begin
                errors++; $display("FAIL rnd_flags[%0d]: got v%b t%b m%b a%b want v%b t%b m%b a%b", n, out_valid, branch_taken, mispredict, misaligned, m_valid, m_taken, m_misp, m_mis);
            end
            checks++; if (redirect_pc !== m_redir) begin errors++; $display("FAIL rnd_redir[%0d]: got %h want %h", n, redirect_pc, m_redir); end
            checks++; if (int'(branch_cnt) != m_bcnt || int'(mispred_cnt) != m_mcnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", n, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_saturation();
        test_jalr();
        test_clk_en_reset();
        test_same_cycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
